// File: rtl/adex_spike_event_fifo.sv
// adex_spike_event_fifo: timestamps spike onsets into a FIFO streamed out as byte pairs.
// Define SPIKE_RATE_EN to add the windowed spike-rate output rate_out.
module adex_spike_event_fifo #(
  parameter int DEPTH = 8,
  parameter int ADDR_W = 3
`ifdef SPIKE_RATE_EN
  , parameter int RATE_WIN_LOG2 = 10
`endif
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            spike_in,
  input  logic            enable,
  input  logic            clr,
  input  logic            rd_strobe,
  output logic [7:0]      data_out,
  output logic            valid,
  output logic            overflow,
  output logic [7:0]      drop_cnt,
  output logic [ADDR_W:0] level
`ifdef SPIKE_RATE_EN
  , output logic [7:0]    rate_out
`endif
);
  logic [15:0] mem [DEPTH];
  logic [15:0] ts_q, head;
  logic [ADDR_W-1:0] wr_q, rd_ptr_q;
  logic [ADDR_W:0] level_q;
  logic [7:0] drop_q;
  logic phase_q, spike_q, rd_q, ovf_q;
  logic evt, pop_byte, pop, full, push, drop;

  assign evt      = spike_in & ~spike_q & enable;
  assign valid    = level_q != '0;
  assign pop_byte = rd_strobe & ~rd_q & valid;
  assign pop      = pop_byte & phase_q;
  assign full     = level_q == (ADDR_W+1)'(DEPTH);
  // A pop on the same edge frees a slot, so a full FIFO still accepts the event.
  assign push     = evt & (~full | pop);
  assign drop     = evt & full & ~pop;
  assign head     = mem[rd_ptr_q];
  assign data_out = !valid ? 8'h00 : phase_q ? head[7:0] : head[15:8];
  assign level    = level_q;
  assign overflow = ovf_q;
  assign drop_cnt = drop_q;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      ts_q <= '0;
      wr_q <= '0;
      rd_ptr_q <= '0;
      level_q <= '0;
      drop_q <= '0;
      phase_q <= 1'b0;
      spike_q <= 1'b0;
      rd_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      spike_q <= spike_in;
      rd_q <= rd_strobe;
      if (clr) begin
        ts_q <= '0;
        wr_q <= '0;
        rd_ptr_q <= '0;
        level_q <= '0;
        drop_q <= '0;
        phase_q <= 1'b0;
        ovf_q <= 1'b0;
      end else begin
        if (enable) ts_q <= ts_q + 16'd1;
        if (push) wr_q <= wr_q + ADDR_W'(1);
        if (pop) rd_ptr_q <= rd_ptr_q + ADDR_W'(1);
        if (pop_byte) phase_q <= ~phase_q;
        level_q <= level_q + (ADDR_W+1)'(push) - (ADDR_W+1)'(pop);
        if (drop) ovf_q <= 1'b1;
        if (drop && drop_q != 8'hFF) drop_q <= drop_q + 8'd1;
      end
    end

  always_ff @(posedge clk)
    if (push && !clr) mem[wr_q] <= ts_q;

`ifdef SPIKE_RATE_EN
  logic [RATE_WIN_LOG2-1:0] win_q;
  logic [7:0] rcnt_q, rcnt_d;
  // The event on the wrapping edge belongs to the window being closed.
  assign rcnt_d = (evt && rcnt_q != 8'hFF) ? rcnt_q + 8'd1 : rcnt_q;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      win_q <= '0;
      rcnt_q <= '0;
      rate_out <= '0;
    end else if (clr) begin
      win_q <= '0;
      rcnt_q <= '0;
      rate_out <= '0;
    end else if (enable) begin
      win_q <= win_q + RATE_WIN_LOG2'(1);
      if (&win_q) begin
        rate_out <= rcnt_d;
        rcnt_q <= '0;
      end else begin
        rcnt_q <= rcnt_d;
      end
    end
`endif
endmodule

// File: tb/tb_adex_spike_event_fifo.sv
// tb_adex_spike_event_fifo: directed and randomized checks against a queue-based reference model.
module tb_adex_spike_event_fifo;
  localparam int DEPTH = 8;
  logic clk = 1'b0, rst_n = 1'b0, spike_in = 1'b0, enable = 1'b0, clr = 1'b0, rd_strobe = 1'b0;
  logic [7:0] data_out, drop_cnt;
  logic valid, overflow;
  logic [3:0] level;
`ifdef SPIKE_RATE_EN
  logic [7:0] rate_out;
`endif
  int n_cmp = 0, n_bad = 0;

  always #5 clk = ~clk;

  adex_spike_event_fifo #(.DEPTH(DEPTH), .ADDR_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .spike_in(spike_in), .enable(enable), .clr(clr),
    .rd_strobe(rd_strobe), .data_out(data_out), .valid(valid), .overflow(overflow),
    .drop_cnt(drop_cnt), .level(level)
`ifdef SPIKE_RATE_EN
    , .rate_out(rate_out)
`endif
  );

  // Reference model: timestamp queue, byte phase, previous input levels, drop bookkeeping.
  logic [15:0] q[$];
  int m_ts, m_drop, m_evt;
  bit m_ph, m_ovf, m_spk, m_rd;

  function automatic void m_reset();
    q.delete();
    m_ts = 0; m_drop = 0; m_evt = 0;
    m_ph = 0; m_ovf = 0; m_spk = 0; m_rd = 0;
  endfunction

  function automatic logic [7:0] m_dout();
    logic [15:0] h;
    if (q.size() == 0) return 8'h00;
    h = q[0];
    return m_ph ? h[7:0] : h[15:8];
  endfunction

  // Drive one cycle of inputs, advance the model across the edge, sample 1 time unit later.
  task automatic cyc(input bit s, input bit e, input bit c, input bit r);
    bit evt, popb, pop;
    spike_in = s; enable = e; clr = c; rd_strobe = r;
    evt = s && !m_spk && e;
    popb = r && !m_rd && q.size() != 0;
    pop = popb && m_ph;
    @(posedge clk);
    if (c) begin
      q.delete(); m_ph = 0; m_ts = 0; m_ovf = 0; m_drop = 0;
    end else begin
      if (evt) m_evt++;
      if (evt && q.size() == DEPTH && !pop) begin
        m_ovf = 1;
        if (m_drop < 255) m_drop++;
      end
      if (pop) void'(q.pop_front());
      if (evt && q.size() < DEPTH) q.push_back(16'(m_ts));
      if (popb) m_ph = !m_ph;
      if (e) m_ts = (m_ts + 1) % 65536;
    end
    m_spk = s; m_rd = r;
    #1;
  endtask

  task automatic test_reset();
    m_reset();
    #2;
    n_cmp++; if (valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid got %0b want 0", valid); end
    n_cmp++; if (data_out !== 8'h00) begin n_bad++; $display("FAIL reset_data got %0h want 0", data_out); end
    #10 rst_n = 1'b1;
    cyc(1, 1, 0, 0); cyc(0, 1, 0, 0); cyc(1, 1, 0, 0); cyc(0, 1, 0, 1);
    n_cmp++; if (level !== 4'(q.size())) begin n_bad++; $display("FAIL pre_reset_level got %0d want %0d", level, q.size()); end
    #1 rst_n = 1'b0;
    #1;
    n_cmp++; if (level !== 4'd0) begin n_bad++; $display("FAIL async_reset_level got %0d want 0", level); end
    n_cmp++; if (valid !== 1'b0) begin n_bad++; $display("FAIL async_reset_valid got %0b want 0", valid); end
    n_cmp++; if (data_out !== 8'h00) begin n_bad++; $display("FAIL async_reset_data got %0h want 0", data_out); end
    n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL async_reset_ovf got %0b want 0", overflow); end
    n_cmp++; if (drop_cnt !== 8'd0) begin n_bad++; $display("FAIL async_reset_drop got %0d want 0", drop_cnt); end
    spike_in = 0; rd_strobe = 0; enable = 0;
    #1 rst_n = 1'b1;
    m_reset();
  endtask

  task automatic test_single();
    while (m_ts != 5) cyc(0, 1, 0, 0);
    cyc(1, 1, 0, 0);
    n_cmp++; if (valid !== 1'b1) begin n_bad++; $display("FAIL single_valid got %0b want 1", valid); end
    n_cmp++; if (level !== 4'd1) begin n_bad++; $display("FAIL single_level got %0d want 1", level); end
    n_cmp++; if (data_out !== 8'h00) begin n_bad++; $display("FAIL single_hi got %0h want 00", data_out); end
    cyc(0, 1, 0, 1);
    n_cmp++; if (data_out !== 8'h05) begin n_bad++; $display("FAIL single_lo got %0h want 05", data_out); end
    cyc(0, 1, 0, 0); cyc(0, 1, 0, 1);
    n_cmp++; if (valid !== 1'b0) begin n_bad++; $display("FAIL single_empty_valid got %0b want 0", valid); end
    n_cmp++; if (data_out !== 8'h00) begin n_bad++; $display("FAIL single_empty_data got %0h want 00", data_out); end
    cyc(0, 1, 0, 0);
  endtask

  task automatic test_hold();
    int t;
    repeat (20) cyc(1, 1, 0, 0);
    cyc(0, 1, 0, 0);
    n_cmp++; if (level !== 4'd1) begin n_bad++; $display("FAIL hold_level got %0d want 1", level); end
    cyc(0, 1, 0, 1); cyc(0, 1, 0, 0); cyc(0, 1, 0, 1); cyc(0, 1, 0, 0);
    t = m_ts;
    repeat (3) cyc(0, 0, 0, 0);
    repeat (3) cyc(1, 0, 0, 0);
    repeat (3) cyc(1, 1, 0, 0);
    n_cmp++; if (level !== 4'd0) begin n_bad++; $display("FAIL disabled_onset_level got %0d want 0", level); end
    cyc(0, 1, 0, 0);
    cyc(1, 1, 0, 0);
    n_cmp++; if (data_out !== 8'((t + 4) >> 8)) begin n_bad++; $display("FAIL frozen_ts_hi got %0h want %0h", data_out, 8'((t + 4) >> 8)); end
    cyc(0, 1, 0, 1);
    n_cmp++; if (data_out !== 8'(t + 4)) begin n_bad++; $display("FAIL frozen_ts_lo got %0h want %0h", data_out, 8'(t + 4)); end
    cyc(0, 1, 0, 0); cyc(0, 1, 0, 1); cyc(0, 1, 0, 0);
  endtask

  task automatic test_overflow();
    cyc(0, 1, 1, 0);
    for (int i = 0; i < 10; i++) begin cyc(1, 1, 0, 0); cyc(0, 1, 0, 0); end
    n_cmp++; if (level !== 4'd8) begin n_bad++; $display("FAIL ovf_level got %0d want 8", level); end
    n_cmp++; if (overflow !== 1'b1) begin n_bad++; $display("FAIL ovf_flag got %0b want 1", overflow); end
    n_cmp++; if (drop_cnt !== 8'd2) begin n_bad++; $display("FAIL ovf_drop got %0d want 2", drop_cnt); end
    for (int b = 0; b < 16; b++) begin
      n_cmp++;
      if (data_out !== ((b % 2) ? 8'(2 * (b / 2)) : 8'h00)) begin
        n_bad++; $display("FAIL ovf_byte%0d got %0h want %0h", b, data_out, (b % 2) ? 8'(2 * (b / 2)) : 8'h00);
      end
      cyc(0, 1, 0, 1); cyc(0, 1, 0, 0);
    end
    n_cmp++; if (valid !== 1'b0) begin n_bad++; $display("FAIL ovf_drained_valid got %0b want 0", valid); end
    n_cmp++; if (overflow !== 1'b1) begin n_bad++; $display("FAIL ovf_sticky got %0b want 1", overflow); end
    cyc(0, 1, 1, 0);
    n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL clr_ovf got %0b want 0", overflow); end
    n_cmp++; if (drop_cnt !== 8'd0) begin n_bad++; $display("FAIL clr_drop got %0d want 0", drop_cnt); end
  endtask

  task automatic test_full_push_pop();
    cyc(0, 1, 1, 0);
    for (int i = 0; i < 8; i++) begin cyc(1, 1, 0, 0); cyc(0, 1, 0, 0); end
    cyc(0, 1, 0, 1); cyc(0, 1, 0, 0);
    cyc(1, 1, 0, 1);
    n_cmp++; if (level !== 4'd8) begin n_bad++; $display("FAIL fullpp_level got %0d want 8", level); end
    n_cmp++; if (drop_cnt !== 8'd0) begin n_bad++; $display("FAIL fullpp_drop got %0d want 0", drop_cnt); end
    n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL fullpp_ovf got %0b want 0", overflow); end
    cyc(0, 1, 0, 0);
    repeat (14) begin cyc(0, 1, 0, 1); cyc(0, 1, 0, 0); end
    n_cmp++; if (level !== 4'd1) begin n_bad++; $display("FAIL fullpp_last_level got %0d want 1", level); end
    n_cmp++; if (data_out !== 8'h00) begin n_bad++; $display("FAIL fullpp_last_hi got %0h want 00", data_out); end
    cyc(0, 1, 0, 1);
    n_cmp++; if (data_out !== 8'h12) begin n_bad++; $display("FAIL fullpp_last_lo got %0h want 12", data_out); end
    cyc(0, 1, 0, 0); cyc(0, 1, 0, 1); cyc(0, 1, 0, 0);
  endtask

  task automatic test_wrap_clr();
    logic [7:0] exp_b [4];
    exp_b[0] = 8'hFF; exp_b[1] = 8'hFF; exp_b[2] = 8'h00; exp_b[3] = 8'h01;
    cyc(0, 1, 1, 0);
    repeat (65535) cyc(0, 1, 0, 0);
    cyc(1, 1, 0, 0); cyc(0, 1, 0, 0); cyc(1, 1, 0, 0); cyc(0, 1, 0, 0);
    for (int b = 0; b < 4; b++) begin
      n_cmp++; if (data_out !== exp_b[b]) begin n_bad++; $display("FAIL wrap_byte%0d got %0h want %0h", b, data_out, exp_b[b]); end
      if (b < 3) begin cyc(0, 1, 0, 1); cyc(0, 1, 0, 0); end
    end
    cyc(1, 1, 1, 1);
    n_cmp++; if (level !== 4'd0) begin n_bad++; $display("FAIL clr_level got %0d want 0", level); end
    n_cmp++; if (valid !== 1'b0) begin n_bad++; $display("FAIL clr_valid got %0b want 0", valid); end
    n_cmp++; if (data_out !== 8'h00) begin n_bad++; $display("FAIL clr_data got %0h want 00", data_out); end
    cyc(0, 1, 0, 0); cyc(0, 1, 0, 0); cyc(1, 1, 0, 0);
    n_cmp++; if (data_out !== 8'h00) begin n_bad++; $display("FAIL clr_phase got %0h want 00", data_out); end
    cyc(0, 1, 0, 1);
    n_cmp++; if (data_out !== 8'h02) begin n_bad++; $display("FAIL clr_ts got %0h want 02", data_out); end
    cyc(0, 1, 0, 0); cyc(0, 1, 0, 1); cyc(0, 1, 0, 0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      cyc($urandom_range(0, 2) == 0, $urandom_range(0, 7) != 0, $urandom_range(0, 299) == 0,
          (i < 1500) ? ($urandom_range(0, 5) == 0) : ($urandom_range(0, 1) == 1));
      n_cmp++; if (valid !== (q.size() != 0)) begin n_bad++; $display("FAIL rnd_valid @%0d got %0b want %0b", i, valid, q.size() != 0); end
      n_cmp++; if (level !== 4'(q.size())) begin n_bad++; $display("FAIL rnd_level @%0d got %0d want %0d", i, level, q.size()); end
      n_cmp++; if (data_out !== m_dout()) begin n_bad++; $display("FAIL rnd_data @%0d got %0h want %0h", i, data_out, m_dout()); end
      n_cmp++; if (overflow !== m_ovf) begin n_bad++; $display("FAIL rnd_ovf @%0d got %0b want %0b", i, overflow, m_ovf); end
      n_cmp++; if (drop_cnt !== 8'(m_drop)) begin n_bad++; $display("FAIL rnd_drop @%0d got %0d want %0d", i, drop_cnt, m_drop); end
    end
  endtask

`ifdef SPIKE_RATE_EN
  task automatic test_rate();
    cyc(0, 1, 1, 0);
    n_cmp++; if (rate_out !== 8'd0) begin n_bad++; $display("FAIL rate_clr got %0d want 0", rate_out); end
    m_evt = 0;
    repeat (1024) cyc($urandom_range(0, 3) == 0, 1, 0, 0);
    n_cmp++; if (rate_out !== 8'((m_evt > 255) ? 255 : m_evt)) begin n_bad++; $display("FAIL rate_win got %0d want %0d", rate_out, m_evt); end
    repeat (1024) cyc(0, 1, 0, 0);
    n_cmp++; if (rate_out !== 8'd0) begin n_bad++; $display("FAIL rate_quiet got %0d want 0", rate_out); end
    m_evt = 0;
    repeat (1024) cyc($urandom_range(0, 3) == 0, 1, 0, 0);
    repeat (100) cyc(0, 1, 0, 0);
    #1 rst_n = 1'b0;
    #1;
    n_cmp++; if (rate_out !== 8'd0) begin n_bad++; $display("FAIL rate_async_reset got %0d want 0", rate_out); end
    spike_in = 0; rd_strobe = 0; enable = 0;
    #1 rst_n = 1'b1;
    m_reset();
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_hold();
    test_overflow();
    test_full_push_pop();
    test_wrap_clr();
    test_random();
`ifdef SPIKE_RATE_EN
    test_rate();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/adex_spike_event_fifo.md
Name: adex_spike_event_fifo

Overview:
Downstream consumer of the AdEx neuron core's spike output. Timestamps each spike onset with a free-running 16-bit cycle counter and buffers the timestamps in a small FIFO. Streams them out as byte pairs over a strobe-driven 8-bit readout, so a slow off-chip host can collect spike trains without missing events. Tracks dropped events and overflow.

Parameters:
DEPTH, 8, number of FIFO entries; must be a power of 2, minimum 2
ADDR_W, 3, log2(DEPTH); must be consistent with DEPTH
RATE_WIN_LOG2, 10, window length exponent used only when the optional feature is compiled in

Ports:
clk  input  1  clock
rst_n  input  1  reset, asynchronous, active-low
spike_in  input  1  spike level from the neuron core, already registered in the clk domain
enable  input  1  neuron run enable; timestamp counter and event capture are active only while high
clr  input  1  synchronous flush of FIFO, counters and flags
rd_strobe  input  1  host read strobe, synchronous level; each rising edge advances the readout by one byte
data_out  output  8  current readout byte
valid  output  1  FIFO not empty
overflow  output  1  sticky flag: at least one event dropped
drop_cnt  output  8  dropped-event count, saturates at 255
level  output  ADDR_W+1  current FIFO occupancy, range 0..DEPTH

Behaviour:
- Reset (rst_n low, async): pointers, occupancy, ts counter, byte phase, spike_d, rd_d, overflow and drop_cnt all go to 0. data_out=0, valid=0.
- Timestamp: ts_q[15:0] increments by 1 on every clk edge where enable=1. Wraps 65535->0 silently. Holds while enable=0.
- Event detect: event = spike_in & ~spike_d & enable. spike_d registers spike_in every cycle, regardless of enable.
  - A spike held high for multiple cycles produces one event.
  - If spike_in rises while enable=0, no event is produced, including when enable later rises with spike_in still high.
- Push: on the edge where event=1, the FIFO writes the pre-increment ts_q value. valid rises in the following cycle. Push-to-valid latency is 1 cycle.
- Readout:
  - Detection: rd_d registers rd_strobe. A pop_byte occurs on a cycle where rd_strobe & ~rd_d & valid.
  - Byte phase 0: data_out = head[15:8]. pop_byte moves to phase 1.
  - Byte phase 1: data_out = head[7:0]. pop_byte moves to phase 0 and pops the entry.
  - data_out is combinational from the head entry and phase; it is 0 when the FIFO is empty.
  - A strobe edge while empty is ignored; phase stays 0.
- Full: when event=1 and level=DEPTH with no pop on the same edge, the event is discarded. overflow is set to 1; drop_cnt increments, saturating at 255.
- Simultaneous push and pop (phase-1 strobe edge plus event on the same edge): both take effect and level is unchanged. This also holds at full, where the event is accepted.
- Push and pop at level=1: the next head is the pushed entry. valid stays 1.
- clr=1 (synchronous, highest priority after reset):
  - Clears pointers, level, phase, ts_q, overflow and drop_cnt.
  - Any event or pop on the same edge is discarded.
  - spike_d and rd_d still update.
- Pointer arithmetic is modulo DEPTH. level is computed as an explicit counter, never as a pointer difference.
- No X on outputs. FIFO storage needs no reset, but data_out must be masked to 0 when valid=0.

Optional Feature:
Macro SPIKE_RATE_EN.
- Defined: adds output port rate_out[7:0] (reset 0).
  - A window counter of RATE_WIN_LOG2 bits runs while enable=1.
  - An internal event counter saturates at 255.
  - When the window counter wraps to 0, rate_out latches the event count for that window, including an event on the wrap edge. The event counter then restarts at 0.
  - clr zeroes the window counter, the event counter and rate_out.
- Undefined: port and logic are absent; all other behaviour is identical.

Test Plan:
- Reset, then enable=1, single 1-cycle spike when ts_q=5 -> next cycle valid=1, level=1, data_out=0x00. One strobe edge -> data_out=0x05. Second strobe edge -> valid=0, data_out=0x00.
- spike_in held high 20 cycles with enable=1 -> exactly one entry pushed. spike rising with enable=0 -> no entry, ts_q frozen.
- 10 spikes with no reads, DEPTH=8 -> level=8, overflow=1, drop_cnt=2. Read 16 bytes -> timestamps of the first 8 spikes in order.
- FIFO full, phase 1; strobe edge and spike onset on the same edge -> level stays 8, drop_cnt unchanged, new timestamp appears last.
- Preset ts_q near 0xFFFE (run 65534 cycles); spikes at ts 0xFFFF and 0x0001 -> bytes FF,FF,00,01. Then clr mid-readout in phase 1 -> level=0, phase 0, overflow=0, drop_cnt=0, ts_q=0.
- With SPIKE_RATE_EN, RATE_WIN_LOG2=4: 3 spikes in the first 16 enabled cycles -> rate_out=3 after the window wrap. A spike-free window -> rate_out=0. Assert rst_n mid-window -> rate_out=0 asynchronously.
